fifo_drain_acc: RTL and testbench

Downstream consumer for the 32-bit, 8-deep `fifo` block. It pulls words out of the FIFO one at a time through the FIFO's read handshake (`rd_en` / `rd_ack` / `rd_err`). It accumulates a 32-bit sum over a fixed-length frame of words, then presents the frame sum on a valid/ready output port. It sits directly on the FIFO read side and issues every read the FIFO sees.

---
 rtl/fifo_drain_acc.sv | 116 +++++++++++
 tb/tb_fifo_drain_acc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_acc.sv
// FIFO read-side consumer: pulls FRAME_LEN words, sums them and offers the sum on valid/ready.
// Define FDRAIN_SAT_EN for a saturating accumulator with sticky ovf; otherwise the sum wraps and ovf is 0.
//
// state   | meaning
// IDLE    | no frame in progress, waiting for en and a non-empty FIFO
// FETCH   | issue one read as soon as the FIFO has data
// WAIT    | one read outstanding, waiting for rd_ack or rd_err
// DONE    | frame sum held on sum_out until sum_ready
module fifo_drain_acc #(
  parameter int FRAME_LEN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        fifo_empty,
  input  logic        fifo_rd_ack,
  input  logic        fifo_rd_err,
  input  logic [31:0] fifo_d_out,
  output logic        fifo_rd_en,
  output logic [31:0] sum_out,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic [3:0]  word_cnt,
  output logic        ovf,
  output logic        busy,
  output logic [7:0]  rd_err_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LEN = 4'(FRAME_LEN);

  logic [1:0] state;
  logic [3:0] cnt_next;

  assign cnt_next   = word_cnt + 4'd1;
  assign fifo_rd_en = (state == S_FETCH) && !fifo_empty;

`ifdef FDRAIN_SAT_EN
  logic [32:0] add_full;
  logic [31:0] sum_next;
  logic        carry;

  assign add_full = {1'b0, sum_out} + {1'b0, fifo_d_out};
  assign carry    = add_full[32];
  // Once pinned at all-ones, any non-zero word carries again, so the sum stays saturated.
  assign sum_next = carry ? 32'hFFFF_FFFF : add_full[31:0];
`else
  logic [31:0] sum_next;

  assign sum_next = sum_out + fifo_d_out;
  assign ovf      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      sum_out    <= 32'd0;
      sum_valid  <= 1'b0;
      word_cnt   <= 4'd0;
      busy       <= 1'b0;
      rd_err_cnt <= 8'd0;
`ifdef FDRAIN_SAT_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (en && !fifo_empty) begin
            state <= S_FETCH;
            busy  <= 1'b1;
          end
        end
        S_FETCH: begin
          if (!fifo_empty) state <= S_WAIT;
        end
        S_WAIT: begin
          if (fifo_rd_err && (rd_err_cnt != 8'hFF)) rd_err_cnt <= rd_err_cnt + 8'd1;
          // An ack in the same cycle as an error still delivers its word.
          if (fifo_rd_ack) begin
            sum_out  <= sum_next;
            word_cnt <= cnt_next;
`ifdef FDRAIN_SAT_EN
            if (carry) ovf <= 1'b1;
`endif
            if (cnt_next == LEN) begin
              state     <= S_DONE;
              sum_valid <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end else if (fifo_rd_err) begin
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (sum_ready) begin
            state     <= S_IDLE;
            sum_valid <= 1'b0;
            sum_out   <= 32'd0;
            word_cnt  <= 4'd0;
            busy      <= 1'b0;
`ifdef FDRAIN_SAT_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_acc.sv
// Directed bench for fifo_drain_acc with a behavioural FIFO read side answering one cycle after each rd_en.
module tb_fifo_drain_acc;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        fifo_empty;
  logic        fifo_rd_ack;
  logic        fifo_rd_err;
  logic [31:0] fifo_d_out;
  logic        fifo_rd_en;
  logic [31:0] sum_out;
  logic        sum_valid;
  logic        sum_ready;
  logic [3:0]  word_cnt;
  logic        ovf;
  logic        busy;
  logic [7:0]  rd_err_cnt;

  always #5 clk = ~clk;

  fifo_drain_acc #(.FRAME_LEN(4)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
    .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err), .fifo_d_out(fifo_d_out),
    .fifo_rd_en(fifo_rd_en), .sum_out(sum_out), .sum_valid(sum_valid),
    .sum_ready(sum_ready), .word_cnt(word_cnt), .ovf(ovf), .busy(busy),
    .rd_err_cnt(rd_err_cnt)
  );

  logic [31:0] q[$];
  int pulse_cyc[$];
  int pulses      = 0;
  int err_at      = -1;
  int cyc         = 0;
  int vectors     = 0;
  int miscompares = 0;
  int base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample rd_en, take the edge, then present the FIFO response for the next cycle.
  task automatic step();
    logic rd;
    #1;
    rd = fifo_rd_en;
    if (rd === 1'b1) begin
      pulses++;
      pulse_cyc.push_back(cyc);
    end
    @(posedge clk);
    cyc++;
    #1;
    fifo_rd_ack = 1'b0;
    fifo_rd_err = 1'b0;
    if (rd === 1'b1) begin
      if (pulses == err_at) fifo_rd_err = 1'b1;
      else begin
        fifo_rd_ack = 1'b1;
        fifo_d_out  = q.pop_front();
      end
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic push(input logic [31:0] w);
    q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max);
    int n = 0;
    while (sum_valid !== 1'b1 && n < max) begin
      step();
      n++;
    end
    check({tag, "_valid"}, sum_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b1; sum_ready = 1'b1;
    fifo_empty = 1'b1; fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0; fifo_d_out = 32'd0;
    push(32'h1100_0011); push(32'h2200_0022); push(32'h3300_0033); push(32'h4400_0044);

    // Reset held two cycles with the FIFO non-empty
    step(); #1; check("rst_rd_en_0", fifo_rd_en, 0);
    step(); #1; check("rst_rd_en_1", fifo_rd_en, 0);
    check("rst_sum_out", sum_out, 0);
    check("rst_sum_valid", sum_valid, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_err_cnt", rd_err_cnt, 0);
    pulses = 0;
    pulse_cyc.delete();

    // Normal frame
    reset = 1'b0;
    wait_valid("norm", 30);
    check("norm_sum", sum_out, 32'hAA00_00AA);
    check("norm_pulses", pulses, 4);
    for (int i = 0; i < 3; i++) check("norm_pulse_gap", pulse_cyc[i+1] - pulse_cyc[i], 2);
    step();
    check("norm_valid_1cyc", sum_valid, 0);
    check("norm_fifo_drained", q.size(), 0);
    check("norm_busy_after", busy, 0);

    // Starvation: only two words, then two more
    sum_ready = 1'b0;
    base = pulses;
    push(32'd5); push(32'd6);
    repeat (12) step();
    #1;
    check("starve_word_cnt", word_cnt, 2);
    check("starve_busy", busy, 1);
    check("starve_rd_en", fifo_rd_en, 0);
    check("starve_pulses", pulses - base, 2);
    push(32'd7); push(32'd8);
    wait_valid("starve", 30);
    check("starve_sum", sum_out, 32'h0000_001A);

    // Backpressure while the next frame's words are already queued
    push(32'h10); push(32'h20); push(32'h30); push(32'h40);
    base = pulses;
    repeat (5) begin
      step();
      check("bp_valid_held", sum_valid, 1);
      check("bp_sum_stable", sum_out, 32'h0000_001A);
    end
    check("bp_no_reads", pulses - base, 0);

    // Release: IDLE one cycle, then FETCH issues the read; second read of this frame errors
    err_at = pulses + 2;
    sum_ready = 1'b1;
    step(); #1;
    check("hs_valid_drop", sum_valid, 0);
    check("hs_sum_clear", sum_out, 0);
    check("hs_cnt_clear", word_cnt, 0);
    check("hs_idle_no_rd", fifo_rd_en, 0);
    step(); #1;
    check("hs_next_rd", fifo_rd_en, 1);
    begin
      int n = 0;
      while (rd_err_cnt !== 8'd1 && n < 20) begin
        step();
        n++;
      end
    end
    check("err_cnt", rd_err_cnt, 1);
    check("err_word_cnt_kept", word_cnt, 1);
    wait_valid("err", 30);
    check("err_sum", sum_out, 32'h0000_00A0);
    check("err_reads", pulses - base, 5);
    step();

    // Overflow: 4 x 8000_0000
    sum_ready = 1'b0;
    push(32'h8000_0000); push(32'h8000_0000); push(32'h8000_0000); push(32'h8000_0000);
    wait_valid("ovf", 30);
`ifdef FDRAIN_SAT_EN
    check("ovf_sum", sum_out, 32'hFFFF_FFFF);
    check("ovf_flag", ovf, 1);
`else
    check("ovf_sum", sum_out, 32'h0000_0000);
    check("ovf_flag", ovf, 0);
`endif
    check("ovf_err_cnt_kept", rd_err_cnt, 1);
    sum_ready = 1'b1;
    step();
    check("ovf_clear", ovf, 0);
    check("ovf_valid_drop", sum_valid, 0);

    // en low keeps the block idle
    en = 1'b0;
    push(32'd1); push(32'd2);
    base = pulses;
    repeat (4) step();
    check("en0_busy", busy, 0);
    check("en0_no_reads", pulses - base, 0);

    // Reset mid-frame discards the partial sum but not before one word lands
    en = 1'b1;
    repeat (3) step();
    check("mid_word_cnt", word_cnt, 1);
    check("mid_sum", sum_out, 1);
    en = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    q.delete();
    fifo_empty = 1'b1; fifo_rd_ack = 1'b0; fifo_rd_err = 1'b0;
    check("mid_rst_cnt", word_cnt, 0);
    check("mid_rst_sum", sum_out, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err_cnt", rd_err_cnt, 0);
    step();
    check("mid_rst_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
